// File: rtl/masked_aes_sequencer_if.sv
// masked_aes_sequencer_if: handshake and data bus between the masked AES sequencer and its PRNG/core environment.
interface masked_aes_sequencer_if #(
    parameter int N_PRNG = 12,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 8
);
    logic              global_start;
    logic [CNT_W-1:0]  num_blocks;
    logic [N_PRNG-1:0] prng_valid;
    logic              core_done;
    logic [DATA_W-1:0] core_ct_share1;
    logic [DATA_W-1:0] core_ct_share2;
    logic              prng_reset;
    logic              prng_reseed;
    logic              core_reset;
    logic              core_start;
    logic [DATA_W-1:0] ct_share1_out;
    logic [DATA_W-1:0] ct_share2_out;
    logic              ct_valid;
    logic [CNT_W-1:0]  block_idx;
    logic              busy;
    logic              done_out;
    logic              error_out;
    logic              trigger_out;

    modport slave (
        input  global_start, num_blocks, prng_valid, core_done, core_ct_share1, core_ct_share2,
        output prng_reset, prng_reseed, core_reset, core_start, ct_share1_out, ct_share2_out,
               ct_valid, block_idx, busy, done_out, error_out, trigger_out
    );

    modport master (
        output global_start, num_blocks, prng_valid, core_done, core_ct_share1, core_ct_share2,
        input  prng_reset, prng_reseed, core_reset, core_start, ct_share1_out, ct_share2_out,
               ct_valid, block_idx, busy, done_out, error_out, trigger_out
    );
endinterface

// File: rtl/masked_aes_sequencer.sv
// masked_aes_sequencer: burst sequencer for the first-order TSM masked AES core with periodic PRNG reseeding.
module masked_aes_sequencer #(
    parameter int N_PRNG       = 12,
    parameter int DATA_W       = 128,
    parameter int CNT_W        = 8,
    parameter int RESEED_EVERY = 4,
    parameter int PRNG_TIMEOUT = 2048
) (
    input logic clk,
    input logic global_reset,
    masked_aes_sequencer_if.slave bus
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] PRNG_RST   = 4'd1;
    localparam logic [3:0] PRNG_REL   = 4'd2;
    localparam logic [3:0] RESEED     = 4'd3;
    localparam logic [3:0] WAIT_PRNG  = 4'd4;
    localparam logic [3:0] CORE_REL   = 4'd5;
    localparam logic [3:0] CORE_START = 4'd6;
    localparam logic [3:0] WAIT_CORE  = 4'd7;
    localparam logic [3:0] CAPTURE    = 4'd8;
    localparam logic [3:0] CORE_RST   = 4'd9;
    localparam logic [3:0] DONE       = 4'd10;
    localparam logic [3:0] ERROR      = 4'd11;
    localparam int TW = $clog2(PRNG_TIMEOUT + 1);
    localparam int RW = $clog2(RESEED_EVERY + 1);

    logic [3:0]        state, state_n;
    logic [CNT_W-1:0]  nb, idx;
    logic [TW-1:0]     tcnt;
    logic [RW-1:0]     rcnt;
    logic [RW-1:0]     rcnt_inc;
    logic [N_PRNG-1:0] valid;
    logic [DATA_W-1:0] ct1, ct2;
    logic              all_valid, idle_like, accept, last, reseed_due;

    assign valid      = bus.prng_valid;
    assign all_valid  = &valid;
    assign idle_like  = state == IDLE || state == DONE || state == ERROR;
    assign accept     = idle_like && bus.global_start;
    assign last       = idx == nb - CNT_W'(1);
    assign rcnt_inc   = rcnt + RW'(1);
    assign reseed_due = rcnt_inc == RW'(RESEED_EVERY);

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: state_n = !bus.global_start ? state : (bus.num_blocks == '0) ? DONE : PRNG_RST;
            PRNG_RST:          state_n = PRNG_REL;
            PRNG_REL:          state_n = RESEED;
            RESEED:            state_n = WAIT_PRNG;
            WAIT_PRNG:         state_n = all_valid ? CORE_REL : (tcnt == TW'(PRNG_TIMEOUT - 1)) ? ERROR : WAIT_PRNG;
            CORE_REL:          state_n = CORE_START;
            CORE_START:        state_n = WAIT_CORE;
            WAIT_CORE:         state_n = bus.core_done ? CAPTURE : WAIT_CORE;
            CAPTURE:           state_n = last ? DONE : reseed_due ? PRNG_REL : CORE_RST;
            CORE_RST:          state_n = CORE_REL;
            default:           state_n = IDLE;
        endcase
    end

    // tcnt sits at zero outside WAIT_PRNG, so every entry starts a fresh timeout window
    always_ff @(posedge clk) begin
        if (global_reset) begin
            state <= IDLE;
            nb    <= '0;
            idx   <= '0;
            tcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            tcnt  <= (state == WAIT_PRNG) ? tcnt + TW'(1) : '0;
            if (accept) begin
                nb   <= bus.num_blocks;
                idx  <= '0;
                rcnt <= '0;
            end else if (state == CAPTURE) begin
                rcnt <= (!last && reseed_due) ? '0 : rcnt_inc;
                idx  <= last ? idx : idx + CNT_W'(1);
            end
        end
    end

    // the two shares live in independent registers so they never meet in common logic
    always_ff @(posedge clk) begin
        if (global_reset)
            ct1 <= '0;
        else if (state == WAIT_CORE && bus.core_done)
            ct1 <= bus.core_ct_share1;
    end

    always_ff @(posedge clk) begin
        if (global_reset)
            ct2 <= '0;
        else if (state == WAIT_CORE && bus.core_done)
            ct2 <= bus.core_ct_share2;
    end

    assign bus.prng_reset    = state == IDLE || state == PRNG_RST;
    assign bus.prng_reseed   = state == RESEED;
    assign bus.core_reset    = state == IDLE || state == PRNG_RST || state == PRNG_REL ||
                               state == RESEED || state == WAIT_PRNG || state == CORE_RST;
    assign bus.core_start    = state == CORE_START;
    assign bus.ct_valid      = state == CAPTURE;
    assign bus.ct_share1_out = ct1;
    assign bus.ct_share2_out = ct2;
    assign bus.block_idx     = idx;
    assign bus.busy          = !idle_like;
    assign bus.done_out      = state == DONE;
    assign bus.error_out     = state == ERROR;
    assign bus.trigger_out   = all_valid;
endmodule

// File: tb/tb_masked_aes_sequencer.sv
// tb_masked_aes_sequencer: directed and randomized bursts against a cycle-level model of the sequencer.
module tb_masked_aes_sequencer;
    localparam int N  = 12;
    localparam int DW = 128;
    localparam int CW = 8;
    localparam int R  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   fixed_lat = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    masked_aes_sequencer_if #(.N_PRNG(N), .DATA_W(DW), .CNT_W(CW)) bus();

    masked_aes_sequencer #(
        .N_PRNG(N), .DATA_W(DW), .CNT_W(CW), .RESEED_EVERY(R), .PRNG_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .global_reset(rst),
        .bus(bus)
    );

    logic [DW-1:0] exp1[$], exp2[$], got1[$], got2[$];
    int dcyc[$], vcyc[$], scyc[$], rcyc[$];

    // behavioural AES core: random latency after each start, done held until core reset
    initial begin
        int lat;
        lat = -1;
        bus.core_done = 1'b0;
        bus.core_ct_share1 = '0;
        bus.core_ct_share2 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_reset) begin
                bus.core_done = 1'b0;
                lat = -1;
            end else if (bus.core_start) begin
                bus.core_done = 1'b0;
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.core_ct_share1 = {$urandom(), $urandom(), $urandom(), $urandom()};
                    bus.core_ct_share2 = {$urandom(), $urandom(), $urandom(), $urandom()};
                    bus.core_done = 1'b1;
                    exp1.push_back(bus.core_ct_share1);
                    exp2.push_back(bus.core_ct_share2);
                    dcyc.push_back(cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.ct_valid) begin
            got1.push_back(bus.ct_share1_out);
            got2.push_back(bus.ct_share2_out);
            vcyc.push_back(cyc);
        end
        if (bus.core_start) scyc.push_back(cyc);
        if (bus.prng_reseed) rcyc.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_logs();
        exp1.delete(); exp2.delete(); got1.delete(); got2.delete();
        dcyc.delete(); vcyc.delete(); scyc.delete(); rcyc.delete();
    endtask

    task automatic run_burst(input int n);
        int t;
        clear_logs();
        bus.num_blocks = CW'(n);
        bus.global_start = 1'b1;
        t = cyc;
        tick();
        bus.global_start = 1'b0;
        chk("start_err_clear", bus.error_out, 0);
        chk("start_done", bus.done_out, n == 0);
        chk("start_busy", bus.busy, n != 0);
        while (!bus.done_out && !bus.error_out && cyc < t + 3000) tick();
        tick();
        chk("burst_done", bus.done_out, 1);
        chk("burst_busy", bus.busy, 0);
        chk("n_reseed", rcyc.size(), (n == 0) ? 0 : 1 + (n - 1) / R);
        chk("n_start", scyc.size(), n);
        chk("n_ctvalid", vcyc.size(), n);
        if (n > 0) begin
            chk("block_idx", bus.block_idx, n - 1);
            chk("reseed_t3", rcyc[0], t + 3);
            chk("start_t6", scyc[0], t + 6);
        end
        for (int i = 0; i < n && i < vcyc.size() && i < dcyc.size(); i++) begin
            chk("ct_latency", vcyc[i], dcyc[i] + 1);
            chk("ct_share1", got1[i], exp1[i]);
            chk("ct_share2", got2[i], exp2[i]);
            if (i + 1 < n && i + 1 < scyc.size())
                chk("turnaround", scyc[i + 1], vcyc[i] + (((i + 1) % R == 0) ? 5 : 3));
        end
    endtask

    initial begin
        int t, r, s;
        rst = 1'b1;
        bus.global_start = 1'b0;
        bus.num_blocks = '0;
        bus.prng_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_prng_reset", bus.prng_reset, 1);
            chk("rst_core_reset", bus.core_reset, 1);
            chk("rst_busy", bus.busy, 0);
        end
        chk("rst_done", bus.done_out, 0);
        chk("rst_error", bus.error_out, 0);
        chk("rst_ctvalid", bus.ct_valid, 0);
        chk("rst_reseed", bus.prng_reseed, 0);
        chk("rst_cstart", bus.core_start, 0);
        chk("rst_idx", bus.block_idx, 0);
        chk("rst_ct1", bus.ct_share1_out, 0);
        chk("rst_ct2", bus.ct_share2_out, 0);
        chk("trigger_low", bus.trigger_out, 0);
        bus.prng_valid = '1;
        #1;
        chk("trigger_high", bus.trigger_out, 1);

        fixed_lat = 14;
        t = cyc;
        run_burst(1);
        chk("done_20", dcyc.size() > 0 ? dcyc[0] : -1, t + 20);
        fixed_lat = 0;

        run_burst(9);

        clear_logs();
        bus.prng_valid = '1;
        bus.prng_valid[3] = 1'b0;
        #1;
        chk("trigger_stuck", bus.trigger_out, 0);
        bus.num_blocks = CW'(2);
        bus.global_start = 1'b1;
        t = cyc;
        tick();
        bus.global_start = 1'b0;
        while (!bus.error_out && cyc < t + 100) tick();
        chk("timeout_cycle", cyc, t + 4 + TO);
        chk("timeout_err", bus.error_out, 1);
        chk("timeout_busy", bus.busy, 0);
        chk("timeout_nostart", scyc.size(), 0);
        tick();
        chk("timeout_hold", bus.error_out, 1);
        bus.prng_valid = '1;

        run_burst(0);

        clear_logs();
        fixed_lat = 40;
        bus.num_blocks = CW'(3);
        bus.global_start = 1'b1;
        t = cyc;
        tick();
        bus.global_start = 1'b0;
        while (scyc.size() == 0 && cyc < t + 100) tick();
        tick();
        tick();
        r = rcyc.size();
        s = scyc.size();
        bus.num_blocks = CW'(5);
        bus.global_start = 1'b1;
        tick();
        bus.global_start = 1'b0;
        tick();
        tick();
        chk("ign_busy", bus.busy, 1);
        chk("ign_reseed", rcyc.size(), r);
        chk("ign_start", scyc.size(), s);
        chk("ign_prng_reset", bus.prng_reset, 0);
        rst = 1'b1;
        bus.global_start = 1'b1;
        tick();
        rst = 1'b0;
        bus.global_start = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_prng_reset", bus.prng_reset, 1);
        chk("abort_done", bus.done_out, 0);
        chk("abort_idx", bus.block_idx, 0);
        for (int i = 0; i < 50; i++) tick();
        chk("abort_noct", vcyc.size(), 0);
        chk("abort_idle", bus.busy, 0);
        fixed_lat = 0;

        for (int k = 0; k < 4; k++) run_burst(int'($urandom_range(1, 10)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
